fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if_id.sv | 51 +++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: instruction width, opcodes, NOP word and FSM states.
// HALT detection is compiled in with FETCH_HALT_DETECT_EN.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDrain,
        StHalted
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: bubble overrides load, neither asserted holds the contents.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               bubble_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [15:0]        pc_plus2_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [15:0]        pc_plus2_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        pc_plus2_q, pc_plus2_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            instr_d    = NOP_INSTR;
            pc_plus2_d = 16'h0000;
            valid_d    = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry hold buffer and the IF/ID register.
// Define FETCH_HALT_DETECT_EN to stop fetching after a HALT opcode enters IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [15:0]        redirectPC,
    output logic [15:0]        imemAddr,
    output logic               imemReq,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               imemDone,
    output logic [INSTR_W-1:0] instrOut,
    output logic [15:0]        pcPlus2Out,
    output logic               validOut,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;

    logic               load, bubble, halt_hit;
    logic [15:0]        pc_plus2;
    logic [INSTR_W-1:0] load_instr;

    assign pc_plus2   = pc_q + 16'd2;
    assign load_instr = (state_q == StHold) ? hold_q : imemData;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = is_halt(load_instr);
    assign halted   = (state_q == StHalted);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        load    = 1'b0;
        bubble  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (flush) begin
                    pc_d    = redirectPC;
                    bubble  = 1'b1;
                    // A still-outstanding response must be swallowed before refetching.
                    state_d = imemDone ? StFetch : StDrain;
                end else if (imemDone) begin
                    if (stall) begin
                        hold_d  = imemData;
                        state_d = StHold;
                    end else begin
                        load    = 1'b1;
                        pc_d    = pc_plus2;
                        state_d = halt_hit ? StHalted : StFetch;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    pc_d    = redirectPC;
                    bubble  = 1'b1;
                    state_d = StFetch;
                end else if (!stall) begin
                    load    = 1'b1;
                    pc_d    = pc_plus2;
                    state_d = halt_hit ? StHalted : StFetch;
                end
            end
            StDrain: begin
                if (flush) begin
                    pc_d   = redirectPC;
                    bubble = 1'b1;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
                if (imemDone) begin
                    state_d = StFetch;
                end
            end
            StHalted: begin
                if (flush) begin
                    pc_d    = redirectPC;
                    bubble  = 1'b1;
                    state_d = StFetch;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    assign imemAddr = pc_q;
    assign imemReq  = (state_q == StFetch);

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .bubble_i   (bubble || rst),
        .instr_i    (load_instr),
        .pc_plus2_i (pc_plus2),
        .instr_o    (instrOut),
        .pc_plus2_o (pcPlus2Out),
        .valid_o    (validOut)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs. a queue model.
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, imemDone;
    logic [15:0] redirectPC, imemData;
    logic [15:0] imemAddr, instrOut, pcPlus2Out;
    logic        imemReq, validOut, halted;

    int checks   = 0;
    int failures = 0;

    // Reference model: in-flight request tracking plus a queue for the parked word.
    logic [15:0] m_pc, m_instr, m_pc2;
    logic        m_valid, m_drain, m_halted;
    logic [15:0] m_held[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirectPC (redirectPC),
        .imemAddr   (imemAddr),
        .imemReq    (imemReq),
        .imemData   (imemData),
        .imemDone   (imemDone),
        .instrOut   (instrOut),
        .pcPlus2Out (pcPlus2Out),
        .validOut   (validOut),
        .halted     (halted)
    );

    function automatic logic m_req();
        return !m_drain && !m_halted && (m_held.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("imemReq", {15'b0, imemReq}, {15'b0, m_req()});
        if (m_req()) chk("imemAddr", imemAddr, m_pc);
        chk("instrOut", instrOut, m_instr);
        chk("validOut", {15'b0, validOut}, {15'b0, m_valid});
        if (m_valid) chk("pcPlus2Out", pcPlus2Out, m_pc2);
        chk("halted", {15'b0, halted}, {15'b0, m_halted});
    endtask

    task automatic m_bubble();
        m_instr = 16'h0800;
        m_pc2   = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic m_load(input logic [15:0] w);
        m_instr  = w;
        m_pc2    = m_pc + 16'd2;
        m_valid  = 1'b1;
        m_pc     = m_pc + 16'd2;
        m_halted = HALT_EN && (w[15:11] == 5'b00000);
    endtask

    task automatic m_update(input logic r, input logic f, input logic s, input logic d,
                            input logic [15:0] rpc, input logic [15:0] dat);
        logic fetching;
        fetching = m_req();
        if (r) begin
            m_pc = 16'h0000;
            m_bubble();
            m_pc2    = 16'h0000;
            m_drain  = 1'b0;
            m_halted = 1'b0;
            m_held.delete();
        end else if (f) begin
            m_pc = rpc;
            m_bubble();
            m_held.delete();
            m_halted = 1'b0;
            m_drain  = (fetching || m_drain) && !d;
        end else if (m_drain) begin
            if (d) m_drain = 1'b0;
            if (!s) m_bubble();
        end else if (m_halted) begin
            if (!s) m_bubble();
        end else if (m_held.size() != 0) begin
            if (!s) m_load(m_held.pop_front());
        end else if (d) begin
            if (s) m_held.push_back(dat);
            else m_load(dat);
        end else if (!s) begin
            m_bubble();
        end
    endtask

    // One clock: check pre-edge outputs against the model, apply inputs, advance the model.
    task automatic cyc(input logic r, input logic f, input logic s, input logic d,
                       input logic [15:0] rpc, input logic [15:0] dat);
        @(negedge clk);
        check_model();
        rst        = r;
        flush      = f;
        stall      = s;
        imemDone   = d;
        redirectPC = rpc;
        imemData   = dat;
        @(posedge clk);
        m_update(r, f, s, d, rpc, dat);
        #1;
    endtask

    initial begin
        logic        r, f, s, d;
        logic [15:0] rpc, dat;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; imemDone = 1'b0;
        redirectPC = 16'h0; imemData = 16'h0;
        m_pc = 16'h0; m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 1'b0;
        m_drain = 1'b0; m_halted = 1'b0;

        // Reset dominates flush and stall
        cyc(1, 1, 1, 0, 16'h1234, 16'h0);
        chk("rst_instr", instrOut, 16'h0800);
        chk("rst_pc2", pcPlus2Out, 16'h0000);
        chk("rst_valid", {15'b0, validOut}, 16'h0);
        chk("rst_addr", imemAddr, 16'h0000);
        chk("rst_req", {15'b0, imemReq}, 16'h1);

        // Back-to-back fetches
        cyc(0, 0, 0, 1, 16'h0, 16'h4001);
        chk("seq1_instr", instrOut, 16'h4001);
        chk("seq1_pc2", pcPlus2Out, 16'h0002);
        chk("seq1_addr", imemAddr, 16'h0002);
        cyc(0, 0, 0, 1, 16'h0, 16'h4002);
        chk("seq2_instr", instrOut, 16'h4002);
        chk("seq2_pc2", pcPlus2Out, 16'h0004);
        chk("seq2_addr", imemAddr, 16'h0004);

        // Response under stall parks in the hold buffer
        cyc(0, 0, 1, 1, 16'h0, 16'h4003);
        chk("hold_req", {15'b0, imemReq}, 16'h0);
        chk("hold_instr", instrOut, 16'h4002);
        cyc(0, 0, 1, 0, 16'h0, 16'h0);
        chk("hold2_instr", instrOut, 16'h4002);
        cyc(0, 0, 0, 0, 16'h0, 16'h0);
        chk("rel_instr", instrOut, 16'h4003);
        chk("rel_pc2", pcPlus2Out, 16'h0006);
        chk("rel_addr", imemAddr, 16'h0006);

        // Flush with request outstanding drains the stale response
        cyc(0, 1, 0, 0, 16'h0100, 16'h0);
        chk("drain_req", {15'b0, imemReq}, 16'h0);
        chk("drain_valid", {15'b0, validOut}, 16'h0);
        cyc(0, 0, 0, 0, 16'h0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0, 16'hBAD1);
        chk("drain_instr", instrOut, 16'h0800);
        chk("drain_req2", {15'b0, imemReq}, 16'h1);
        chk("drain_addr", imemAddr, 16'h0100);

        // Flush beats stall on a valid IF/ID
        cyc(0, 0, 0, 1, 16'h0, 16'h5005);
        chk("pre_fs_valid", {15'b0, validOut}, 16'h1);
        cyc(0, 1, 1, 0, 16'h0200, 16'h0);
        chk("fs_valid", {15'b0, validOut}, 16'h0);
        chk("fs_instr", instrOut, 16'h0800);
        cyc(0, 0, 0, 1, 16'h0, 16'hBAD2);

        // Flush coinciding with a response, then PC wrap
        cyc(0, 1, 0, 1, 16'hFFFE, 16'hBAD3);
        chk("wrap_pre_addr", imemAddr, 16'hFFFE);
        chk("wrap_pre_req", {15'b0, imemReq}, 16'h1);
        cyc(0, 0, 0, 1, 16'h0, 16'h6006);
        chk("wrap_instr", instrOut, 16'h6006);
        chk("wrap_pc2", pcPlus2Out, 16'h0000);
        chk("wrap_addr", imemAddr, 16'h0000);

        // HALT opcode
        cyc(0, 0, 0, 1, 16'h0, 16'h0000);
        chk("halt_instr", instrOut, 16'h0000);
        chk("halt_valid", {15'b0, validOut}, 16'h1);
        chk("halt_flag", {15'b0, halted}, {15'b0, HALT_EN});
        chk("halt_req", {15'b0, imemReq}, {15'b0, !HALT_EN});
        if (HALT_EN) begin
            cyc(0, 0, 0, 0, 16'h0, 16'h0);
            chk("halt_bubble", {15'b0, validOut}, 16'h0);
            chk("halt_stay", {15'b0, halted}, 16'h1);
            cyc(0, 1, 0, 0, 16'h0020, 16'h0);
            chk("resume_addr", imemAddr, 16'h0020);
            chk("resume_req", {15'b0, imemReq}, 16'h1);
            chk("resume_halted", {15'b0, halted}, 16'h0);
        end

        // Randomized traffic; the memory only responds while a request is in flight
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            f   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 3) == 0);
            d   = (m_req() || m_drain) && ($urandom_range(0, 1) == 1);
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
            dat = 16'($urandom);
            cyc(r, f, s, d, rpc, dat);
        end
        @(negedge clk);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
